// File: rtl/ball_motion_ctrl.sv
// Frame-paced ball motion controller: moves the ball centre once per frame,
// reflecting off the visible-area walls and counting reflections.
module ball_motion_ctrl #(
   parameter int BALL_SIZE  = 20,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int X_INIT     = 320,
   parameter int Y_INIT     = 240,
   parameter int SPEED_INIT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       run,
   input  logic       step_req,
   input  logic       cfg_valid,
   input  logic [2:0] cfg_speed_x,
   input  logic [2:0] cfg_speed_y,
   output logic       cfg_ready,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic       busy,
   output logic       upd_done,
   output logic [7:0] bounce_cnt
);

   localparam logic [10:0] POS_MIN = 11'(BALL_SIZE);
   localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
   localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - BALL_SIZE);

   typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, DONE} state_t;

   state_t     state;
   logic [2:0] speed_x;
   logic [2:0] speed_y;
   logic       step_pending;
   logic [11:0] x_nxt;
   logic [11:0] y_nxt;

   // Result packing: {wall_hit, new_dir, new_pos[9:0]}. Math at 11 bits so the
   // sum never wraps before it is clamped to the wall.
   function automatic logic [11:0] axis_step(input logic [9:0]  pos,
                                             input logic        dir,
                                             input logic [2:0]  spd,
                                             input logic [10:0] lim);
      logic [10:0] pos_w;
      logic [10:0] spd_w;
      pos_w = {1'b0, pos};
      spd_w = {8'd0, spd};
      if (dir) begin
         if (pos_w + spd_w >= lim)
            axis_step = {1'b1, 1'b0, 10'(lim)};
         else
            axis_step = {1'b0, 1'b1, 10'(pos_w + spd_w)};
      end else begin
         if (pos_w <= POS_MIN + spd_w)
            axis_step = {1'b1, 1'b1, 10'(POS_MIN)};
         else
            axis_step = {1'b0, 1'b0, 10'(pos_w - spd_w)};
      end
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign x_nxt     = axis_step(ball_x, dir_x, speed_x, X_MAX);
   assign y_nxt     = axis_step(ball_y, dir_y, speed_y, Y_MAX);
   assign cfg_ready = rst_n && (state == IDLE);
   assign busy      = rst_n && (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         ball_x       <= 10'(X_INIT);
         ball_y       <= 10'(Y_INIT);
         dir_x        <= 1'b1;
         dir_y        <= 1'b1;
         speed_x      <= 3'(SPEED_INIT);
         speed_y      <= 3'(SPEED_INIT);
         bounce_cnt   <= 8'd0;
         step_pending <= 1'b0;
         upd_done     <= 1'b0;
      end else begin
         upd_done <= 1'b0;
         if (step_req && !run)
            step_pending <= 1'b1;
         if (cfg_valid && (state == IDLE)) begin
            speed_x <= cfg_speed_x;
            speed_y <= cfg_speed_y;
         end
         case (state)
            IDLE: begin
               if (frame_start && (run || step_pending)) begin
                  state        <= UPD_X;
                  step_pending <= 1'b0;
               end
            end
            UPD_X: begin
               ball_x <= x_nxt[9:0];
               dir_x  <= x_nxt[10];
               if (x_nxt[11])
                  bounce_cnt <= sat_inc(bounce_cnt);
               state <= UPD_Y;
            end
            UPD_Y: begin
               ball_y <= y_nxt[9:0];
               dir_y  <= y_nxt[10];
               if (y_nxt[11])
                  bounce_cnt <= sat_inc(bounce_cnt);
               upd_done <= 1'b1;
               state    <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: scoreboard of expected positions checked on
// each upd_done, plus scenario tasks for timing, walls, corners, config and reset.
module tb_ball_motion_ctrl;

   localparam int BALL = 20;
   localparam int XMAX = 620;
   localparam int YMAX = 460;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       run = 1'b0;
   logic       step_req = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [2:0] cfg_speed_x = 3'd0;
   logic [2:0] cfg_speed_y = 3'd0;
   logic       cfg_ready, dir_x, dir_y, busy, upd_done;
   logic [9:0] ball_x, ball_y;
   logic [7:0] bounce_cnt;
   logic       s_cfg_ready, s_dir_x, s_dir_y, s_busy, s_upd_done;
   logic [9:0] s_ball_x, s_ball_y;
   logic [7:0] s_bounce_cnt;

   ball_motion_ctrl dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .run(run),
      .step_req(step_req), .cfg_valid(cfg_valid), .cfg_speed_x(cfg_speed_x),
      .cfg_speed_y(cfg_speed_y), .cfg_ready(cfg_ready), .ball_x(ball_x),
      .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y), .busy(busy),
      .upd_done(upd_done), .bounce_cnt(bounce_cnt)
   );

   // Tiny arena (x,y in [20,24]): at speed 7 every update hits both walls.
   ball_motion_ctrl #(.BALL_SIZE(20), .H_ACTIVE(44), .V_ACTIVE(44),
                      .X_INIT(22), .Y_INIT(22), .SPEED_INIT(2)) dut_small (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .run(run),
      .step_req(step_req), .cfg_valid(cfg_valid), .cfg_speed_x(cfg_speed_x),
      .cfg_speed_y(cfg_speed_y), .cfg_ready(s_cfg_ready), .ball_x(s_ball_x),
      .ball_y(s_ball_y), .dir_x(s_dir_x), .dir_y(s_dir_y), .busy(s_busy),
      .upd_done(s_upd_done), .bounce_cnt(s_bounce_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {int x; int y; bit dx; bit dy; int bc;} exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   int m_x, m_y, m_sx, m_sy, m_bc;
   bit m_dx, m_dy;

   function automatic void axis(input int p, input bit d, input int s, input int hi,
                                output int np, output bit nd, output bit hit);
      np = p; nd = d; hit = 1'b0;
      if (d) begin
         if (p + s >= hi) begin np = hi; nd = 1'b0; hit = 1'b1; end
         else np = p + s;
      end else begin
         if (p <= BALL + s) begin np = BALL; nd = 1'b1; hit = 1'b1; end
         else np = p - s;
      end
   endfunction

   task automatic model_reset();
      m_x = 320; m_y = 240; m_dx = 1'b1; m_dy = 1'b1;
      m_sx = 2; m_sy = 2; m_bc = 0;
   endtask

   task automatic push_expected();
      int np; bit nd, hit;
      exp_t e;
      axis(m_x, m_dx, m_sx, XMAX, np, nd, hit);
      m_x = np; m_dx = nd;
      if (hit && m_bc < 255) m_bc++;
      axis(m_y, m_dy, m_sy, YMAX, np, nd, hit);
      m_y = np; m_dy = nd;
      if (hit && m_bc < 255) m_bc++;
      e.x = m_x; e.y = m_y; e.dx = m_dx; e.dy = m_dy; e.bc = m_bc;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (upd_done === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_update: upd_done=1 got, no update expected");
         end else begin
            mon_e = sb_q.pop_front();
            if (ball_x !== 10'(mon_e.x) || ball_y !== 10'(mon_e.y) || dir_x !== mon_e.dx ||
                dir_y !== mon_e.dy || bounce_cnt !== 8'(mon_e.bc)) begin
               errors++;
               $display("FAIL update_result: got x=%0d y=%0d dx=%0b dy=%0b bc=%0d, expected x=%0d y=%0d dx=%0b dy=%0b bc=%0d",
                        ball_x, ball_y, dir_x, dir_y, bounce_cnt,
                        mon_e.x, mon_e.y, mon_e.dx, mon_e.dy, mon_e.bc);
            end
         end
      end
   end

   // Called at a negedge with the DUT idle; optional config on the trigger edge.
   task automatic fire(input bit use_cfg, input int sx, input int sy);
      int n;
      run = 1'b1;
      frame_start = 1'b1;
      if (use_cfg) begin
         cfg_valid = 1'b1; cfg_speed_x = 3'(sx); cfg_speed_y = 3'(sy);
         m_sx = sx; m_sy = sy;
      end
      push_expected();
      @(negedge clk);
      frame_start = 1'b0;
      cfg_valid = 1'b0;
      n = 0;
      while ((sb_q.size() != 0 || busy) && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 10) begin
         errors++;
         $display("FAIL update_timeout: pending=%0d busy=%0b, required pending=0 busy=0", sb_q.size(), busy);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (ball_x !== 10'd320 || ball_y !== 10'd240 || dir_x !== 1'b1 || dir_y !== 1'b1 ||
          bounce_cnt !== 8'd0 || busy !== 1'b0 || upd_done !== 1'b0 || cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got x=%0d y=%0d dx=%0b dy=%0b bc=%0d busy=%0b done=%0b rdy=%0b, required 320 240 1 1 0 0 0 0",
                  ball_x, ball_y, dir_x, dir_y, bounce_cnt, busy, upd_done, cfg_ready);
      end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %0b, required 1", cfg_ready);
      end
   endtask

   task automatic test_single_update();
      run = 1'b1;
      frame_start = 1'b1;
      push_expected();
      @(negedge clk);
      frame_start = 1'b0;
      checks++;
      if (busy !== 1'b1 || ball_x !== 10'd320) begin
         errors++;
         $display("FAIL e0_state: got busy=%0b x=%0d, required busy=1 x=320", busy, ball_x);
      end
      @(negedge clk);
      checks++;
      if (ball_x !== 10'd322 || ball_y !== 10'd240 || upd_done !== 1'b0) begin
         errors++;
         $display("FAIL e1_x_update: got x=%0d y=%0d done=%0b, required x=322 y=240 done=0", ball_x, ball_y, upd_done);
      end
      @(negedge clk);
      checks++;
      if (ball_y !== 10'd242 || upd_done !== 1'b1) begin
         errors++;
         $display("FAIL e2_y_update: got y=%0d done=%0b, required y=242 done=1", ball_y, upd_done);
      end
      @(negedge clk);
      checks++;
      if (upd_done !== 1'b0 || busy !== 1'b0 || bounce_cnt !== 8'd0) begin
         errors++;
         $display("FAIL e3_idle: got done=%0b busy=%0b bc=%0d, required 0 0 0", upd_done, busy, bounce_cnt);
      end
   endtask

   task automatic test_walls();
      repeat (42) fire(1'b1, 7, 0);
      fire(1'b1, 2, 0);
      checks++;
      if (ball_x !== 10'd618 || dir_x !== 1'b1) begin
         errors++;
         $display("FAIL approach_right: got x=%0d dx=%0b, required x=618 dx=1", ball_x, dir_x);
      end
      fire(1'b0, 0, 0);
      checks++;
      if (ball_x !== 10'd620 || dir_x !== 1'b0 || bounce_cnt !== 8'd1) begin
         errors++;
         $display("FAIL right_wall: got x=%0d dx=%0b bc=%0d, required x=620 dx=0 bc=1", ball_x, dir_x, bounce_cnt);
      end
      repeat (85) fire(1'b1, 7, 0);
      fire(1'b1, 2, 0);
      fire(1'b0, 0, 0);
      checks++;
      if (ball_x !== 10'd21 || dir_x !== 1'b0) begin
         errors++;
         $display("FAIL approach_left: got x=%0d dx=%0b, required x=21 dx=0", ball_x, dir_x);
      end
      fire(1'b0, 0, 0);
      checks++;
      if (ball_x !== 10'd20 || dir_x !== 1'b1 || bounce_cnt !== 8'd2) begin
         errors++;
         $display("FAIL left_wall: got x=%0d dx=%0b bc=%0d, required x=20 dx=1 bc=2", ball_x, dir_x, bounce_cnt);
      end
   endtask

   task automatic test_corner();
      repeat (85) fire(1'b1, 7, 0);
      fire(1'b1, 4, 0);
      repeat (31) fire(1'b1, 0, 7);
      checks++;
      if (ball_x !== 10'd619 || ball_y !== 10'd459 || dir_x !== 1'b1 || dir_y !== 1'b1) begin
         errors++;
         $display("FAIL corner_setup: got (%0d,%0d) dirs %0b%0b, required (619,459) dirs 11", ball_x, ball_y, dir_x, dir_y);
      end
      fire(1'b1, 2, 2);
      checks++;
      if (ball_x !== 10'd620 || ball_y !== 10'd460 || dir_x !== 1'b0 || dir_y !== 1'b0 || bounce_cnt !== 8'd4) begin
         errors++;
         $display("FAIL corner_hit: got (%0d,%0d) dirs %0b%0b bc=%0d, required (620,460) dirs 00 bc=4",
                  ball_x, ball_y, dir_x, dir_y, bounce_cnt);
      end
   endtask

   task automatic test_cfg_busy();
      int n;
      run = 1'b1;
      frame_start = 1'b1;
      push_expected();
      @(negedge clk);
      frame_start = 1'b0;
      cfg_valid = 1'b1; cfg_speed_x = 3'd5; cfg_speed_y = 3'd7;
      n = 0;
      while (busy && n < 8) begin
         checks++;
         if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_while_busy: got %0b, required 0", cfg_ready);
         end
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_on_idle: got busy=%0b rdy=%0b, required busy=0 rdy=1", busy, cfg_ready);
      end
      m_sx = 5; m_sy = 7;
      @(negedge clk);
      cfg_valid = 1'b0;
      checks++;
      if (ball_x !== 10'd618 || ball_y !== 10'd458) begin
         errors++;
         $display("FAIL pre_cfg_move: got (%0d,%0d), required (618,458)", ball_x, ball_y);
      end
      fire(1'b0, 0, 0);
      checks++;
      if (ball_x !== 10'd613 || ball_y !== 10'd451) begin
         errors++;
         $display("FAIL cfg_speed_used: got (%0d,%0d), required (613,451)", ball_x, ball_y);
      end
   endtask

   task automatic test_step_mode();
      int n;
      run = 1'b0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (ball_x !== 10'(m_x) || ball_y !== 10'(m_y) || busy !== 1'b0) begin
         errors++;
         $display("FAIL run0_no_motion: got (%0d,%0d) busy=%0b, required (%0d,%0d) busy=0", ball_x, ball_y, busy, m_x, m_y);
      end
      run = 1'b1; step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0; run = 1'b0; frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (ball_x !== 10'(m_x) || busy !== 1'b0) begin
         errors++;
         $display("FAIL step_ignored_run1: got x=%0d busy=%0b, required x=%0d busy=0", ball_x, busy, m_x);
      end
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0; frame_start = 1'b1;
      push_expected();
      @(negedge clk);
      frame_start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (sb_q.size() != 0 || ball_x !== 10'(m_x) || ball_y !== 10'(m_y)) begin
         errors++;
         $display("FAIL step_update: got (%0d,%0d) pending=%0d, required (%0d,%0d) pending=0", ball_x, ball_y, sb_q.size(), m_x, m_y);
      end
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (ball_x !== 10'(m_x) || ball_y !== 10'(m_y)) begin
         errors++;
         $display("FAIL step_once_only: got (%0d,%0d), required (%0d,%0d)", ball_x, ball_y, m_x, m_y);
      end
      run = 1'b1; frame_start = 1'b1;
      push_expected();
      repeat (3) @(negedge clk);
      frame_start = 1'b0;
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (busy) n++;
      end
      checks++;
      if (n != 0 || sb_q.size() != 0 || ball_x !== 10'(m_x) || ball_y !== 10'(m_y)) begin
         errors++;
         $display("FAIL busy_frame_ignored: got busy_cycles=%0d pending=%0d (%0d,%0d), required 0 0 (%0d,%0d)",
                  n, sb_q.size(), ball_x, ball_y, m_x, m_y);
      end
   endtask

   task automatic test_bounce_saturation();
      fire(1'b1, 7, 7);
      repeat (139) fire(1'b0, 0, 0);
      checks++;
      if (s_bounce_cnt !== 8'd255) begin
         errors++;
         $display("FAIL bounce_saturate: got %0d, required 255", s_bounce_cnt);
      end
      fire(1'b0, 0, 0);
      checks++;
      if (s_bounce_cnt !== 8'd255) begin
         errors++;
         $display("FAIL bounce_hold_255: got %0d, required 255", s_bounce_cnt);
      end
   endtask

   task automatic test_reset_mid_update();
      run = 1'b1;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (ball_x !== 10'd320 || ball_y !== 10'd240 || dir_x !== 1'b1 || dir_y !== 1'b1 ||
          bounce_cnt !== 8'd0 || busy !== 1'b0 || upd_done !== 1'b0 || cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_update: got x=%0d y=%0d dx=%0b dy=%0b bc=%0d busy=%0b done=%0b rdy=%0b, required 320 240 1 1 0 0 0 0",
                  ball_x, ball_y, dir_x, dir_y, bounce_cnt, busy, upd_done, cfg_ready);
      end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      fire(1'b0, 0, 0);
      checks++;
      if (ball_x !== 10'd322 || ball_y !== 10'd242 || bounce_cnt !== 8'd0) begin
         errors++;
         $display("FAIL post_reset_speed: got (%0d,%0d) bc=%0d, required (322,242) bc=0", ball_x, ball_y, bounce_cnt);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_update();
      test_walls();
      test_corner();
      test_cfg_busy();
      test_step_mode();
      test_bounce_saturation();
      test_reset_mid_update();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drained: got %0d pending, required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
